// File: rtl/wb_uart_tx_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register map,
// STATUS bit layout and the transmit FSM encoding.
package wb_uart_tx_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_DIV    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // A zero divider would stall the bit counter, so it behaves as one clock.
  function automatic logic [15:0] div_clamp(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/wb_uart_tx_fifo.sv
// Synchronous FIFO with registered pointers and an occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign count   = cnt_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-slave 8N1 UART transmitter: byte FIFO, programmable bit period,
// LSB-first serialiser driving a registered, idle-high line.
module wb_uart_tx
  import wb_uart_tx_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = 16'd4167,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        uart_tx_o,
  output logic        irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic        ack_q;
  logic [1:0]  reg_sel;
  logic        wb_req;
  logic        wr_hit;
  logic        push_req;
  logic [15:0] div_q;
  logic        ovf_q;
  logic [31:0] rd_data;

  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  tx_state_e   state_q, state_d;
  logic        tx_q, tx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  byte_q;
  logic [15:0] div_lat_q;
  logic        load;
  logic        bit_end;
  logic        busy;

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  assign reg_sel  = wbs_adr_i[3:2];
  assign wb_req   = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr_hit   = wbs_cyc_i & wbs_stb_i & ack_q & wbs_we_i;
  assign push_req = wr_hit & (reg_sel == REG_DATA) & wbs_sel_i[0];

  // Wishbone handshake: ack one cycle after request, then forced low for a cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= wb_req;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      div_q <= DEFAULT_DIV;
      ovf_q <= 1'b0;
    end else begin
      if (wr_hit && reg_sel == REG_DIV) begin
        if (wbs_sel_i[0]) div_q[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) div_q[15:8] <= wbs_dat_i[15:8];
      end
      if (push_req && fifo_full && !fifo_pop) begin
        ovf_q <= 1'b1;
      end else if (wr_hit && reg_sel == REG_STATUS && wbs_sel_i[0] && wbs_dat_i[STAT_OVF]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push_req),
    .pop   (fifo_pop),
    .wdata (wbs_dat_i[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_end = (cnt_q == 16'd0);
  assign busy    = (state_q != TX_IDLE);
  assign irq_o   = fifo_empty & ~busy;

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    cnt_d    = cnt_q - 16'd1;
    idx_d    = idx_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        cnt_d = cnt_q;
        tx_d  = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
          tx_d     = 1'b0;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_d = TX_DATA;
          tx_d    = byte_q[0];
          idx_d   = 3'd0;
          cnt_d   = div_lat_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_d = div_lat_q - 16'd1;
          if (idx_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = byte_q[idx_q + 3'd1];
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          cnt_d = div_lat_q - 16'd1;
          // Chain straight into the next start bit so queued bytes leave no gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            load     = 1'b1;
            tx_d     = 1'b0;
            state_d  = TX_START;
          end else begin
            tx_d    = 1'b1;
            state_d = TX_IDLE;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (load) cnt_d = div_clamp(div_q) - 16'd1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= TX_IDLE;
      tx_q    <= 1'b1;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // The divider is captured per frame so DIV writes only affect the next byte.
  always_ff @(posedge wb_clk_i) begin
    if (load) begin
      byte_q    <= fifo_rdata;
      div_lat_q <= div_clamp(div_q);
    end
  end

  always_comb begin
    rd_data = 32'd0;
    if (ack_q) begin
      case (reg_sel)
        REG_DIV: rd_data[15:0] = div_q;
        REG_STATUS: begin
          rd_data[STAT_FULL]             = fifo_full;
          rd_data[STAT_EMPTY]            = fifo_empty;
          rd_data[STAT_BUSY]             = busy;
          rd_data[STAT_OVF]              = ovf_q;
          rd_data[STAT_CNT_LSB+3:STAT_CNT_LSB] = 4'(fifo_count);
        end
        default: rd_data = 32'd0;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rd_data;
  assign uart_tx_o = tx_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Scoreboard bench for wb_uart_tx: register reads and decoded UART bytes are
// queued as expectations and checked by independent monitor processes.
module tb_wb_uart_tx;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0, dat = 32'd0;
  logic        ack;
  logic [31:0] dat_o;
  logic        uart_tx;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int mon_div = 4167;
  int frames_done = 0;
  int starts_n = 0;

  logic [31:0] rd_exp[$];
  string       rd_nm[$];
  logic [7:0]  exp_q[$];
  int          st_q[$];

  wb_uart_tx dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (wb_rst_i),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .uart_tx_o (uart_tx),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Register-read monitor
  initial begin
    forever begin
      @(negedge clk);
      if (ack && !we) begin
        if (rd_exp.size() == 0) chk("unexpected_read_ack", 32'd1, 32'd0);
        else chk(rd_nm.pop_front(), dat_o, rd_exp.pop_front());
      end
    end
  end

  // UART line monitor: decodes frames and checks every sample of every bit.
  initial begin
    int         st;
    int         dv;
    logic       lvl;
    logic       bad;
    logic       aborted;
    logic [7:0] rx_b;
    forever begin
      @(negedge clk);
      if (!wb_rst_i && uart_tx === 1'b0) begin
        st = cyc_n; dv = mon_div; bad = 1'b0; aborted = 1'b0; rx_b = 8'h00; lvl = 1'b0;
        starts_n++;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int k = 0; k < dv && !aborted; k++) begin
            if (!(b == 0 && k == 0)) @(negedge clk);
            if (wb_rst_i) aborted = 1'b1;
            else if (k == 0) begin
              lvl = uart_tx;
              if (b >= 1 && b <= 8) rx_b[b-1] = lvl;
              if (b == 0 && lvl !== 1'b0) bad = 1'b1;
              if (b == 9 && lvl !== 1'b1) bad = 1'b1;
            end else if (uart_tx !== lvl) bad = 1'b1;
          end
        end
        if (!aborted) begin
          st_q.push_back(st);
          chk("frame_shape", {31'd0, bad}, 32'd0);
          if (exp_q.size() == 0) chk("unexpected_frame", {24'd0, rx_b}, 32'hFFFF_FFFF);
          else chk("rx_byte", {24'd0, rx_b}, {24'd0, exp_q.pop_front()});
          frames_done++;
        end
      end
    end
  end

  task automatic wb_xfer(input logic w, input logic [1:0] r, input logic [31:0] d,
                         input logic [3:0] s, output int ack_cyc);
    int n;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = {28'd0, r, 2'b00}; dat = d; sel = s;
    n = 0; ack_cyc = -1;
    while (ack_cyc < 0 && n < 20) begin
      @(negedge clk); n++;
      if (ack) ack_cyc = cyc_n;
    end
    if (ack_cyc < 0) chk("wb_ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wb_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s,
                          output int ack_cyc);
    wb_xfer(1'b1, r, d, s, ack_cyc);
  endtask

  task automatic wb_read(input logic [1:0] r, input logic [31:0] exp, input string nm);
    int a;
    rd_exp.push_back(exp);
    rd_nm.push_back(nm);
    wb_xfer(1'b0, r, 32'd0, 4'hF, a);
  endtask

  task automatic wait_cyc(input int target);
    do @(negedge clk); while (cyc_n < target);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frames_done < n && t < budget) begin
      @(negedge clk); t++;
    end
    chk("frames_done", frames_done, n);
  endtask

  initial begin
    int a, a2, s0, s1, saved;

    // Reset state
    repeat (3) @(negedge clk);
    chk("tx_in_reset", {31'd0, uart_tx}, 32'd1);
    wb_rst_i = 1'b0;
    @(negedge clk);
    chk("tx_after_reset", {31'd0, uart_tx}, 32'd1);
    chk("irq_after_reset", {31'd0, irq}, 32'd1);
    chk("ack_after_reset", {31'd0, ack}, 32'd0);
    chk("dat_o_idle", dat_o, 32'd0);
    wb_read(2'd2, 32'h02, "status_reset");
    wb_read(2'd1, 32'h1047, "div_reset");
    wb_read(2'd0, 32'h0, "data_reads_zero");
    wb_read(2'd3, 32'h0, "reg3_reads_zero");

    // DIV=4, single byte 0x55
    wb_write(2'd1, 32'd4, 4'b0011, a);
    mon_div = 4;
    wb_read(2'd1, 32'd4, "div_4");
    exp_q.push_back(8'h55);
    wb_write(2'd0, 32'h55, 4'b0001, a);
    wait_cyc(a + 1);
    chk("irq_low_pop_cycle", {31'd0, irq}, 32'd0);
    wb_read(2'd2, 32'h06, "status_busy");
    wait_cyc(a + 41);
    chk("irq_low_last_stop", {31'd0, irq}, 32'd0);
    wait_cyc(a + 42);
    chk("irq_high_frame_end", {31'd0, irq}, 32'd1);
    chk("tx_idle_frame_end", {31'd0, uart_tx}, 32'd1);
    wait_frames(1, 200);
    if (st_q.size() > 0) chk("start_latency", st_q.pop_front(), a + 2);
    else chk("start_recorded", 32'd0, 32'd1);

    // DIV=4, back-to-back 0xA5, 0x3C
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    wb_write(2'd0, 32'hA5, 4'b0001, a);
    wb_write(2'd0, 32'h3C, 4'b0001, a2);
    wait_frames(3, 300);
    if (st_q.size() >= 2) begin
      s0 = st_q.pop_front();
      s1 = st_q.pop_front();
      chk("b2b_spacing", s1 - s0, 32'd40);
    end else chk("b2b_starts", st_q.size(), 32'd2);

    // DIV=200, ten quick writes: one in flight, eight queued, one dropped
    wb_write(2'd1, 32'd200, 4'b0011, a);
    mon_div = 200;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'h10 + 8'(i));
      wb_write(2'd0, 32'h10 + i, 4'b0001, a);
    end
    wb_read(2'd2, 32'h8D, "status_full_ovf");
    wb_write(2'd2, 32'h08, 4'b0001, a);
    wb_read(2'd2, 32'h85, "status_ovf_cleared");
    wait_frames(12, 20000);
    st_q.delete();
    @(negedge clk);
    wb_read(2'd2, 32'h02, "status_drained");

    // DIV=0 acts as 1: 0xFF frame lasts 10 clocks
    wb_write(2'd1, 32'd0, 4'b0011, a);
    mon_div = 1;
    wb_read(2'd1, 32'd0, "div_0");
    exp_q.push_back(8'hFF);
    wb_write(2'd0, 32'hFF, 4'b0001, a);
    wait_cyc(a + 11);
    chk("irq_low_div0_end", {31'd0, irq}, 32'd0);
    wait_cyc(a + 12);
    chk("irq_high_div0_end", {31'd0, irq}, 32'd1);
    wait_frames(13, 100);
    if (st_q.size() > 0) chk("start_latency_div0", st_q.pop_front(), a + 2);
    else chk("start_recorded_div0", 32'd0, 32'd1);

    // DIV=8, reset during data bit 3 of 0x00 with another byte queued
    wb_write(2'd1, 32'd8, 4'b0011, a);
    mon_div = 8;
    wb_write(2'd0, 32'h00, 4'b0001, a);
    wb_write(2'd0, 32'h77, 4'b0001, a2);
    wait_cyc(a + 37);
    chk("tx_low_bit3", {31'd0, uart_tx}, 32'd0);
    wb_rst_i = 1'b1;
    #1;
    chk("tx_async_reset", {31'd0, uart_tx}, 32'd1);
    repeat (3) @(negedge clk);
    wb_rst_i = 1'b0;
    saved = starts_n;
    repeat (100) @(negedge clk);
    chk("no_frame_after_reset", starts_n, saved);
    chk("irq_after_midframe_reset", {31'd0, irq}, 32'd1);
    wb_read(2'd2, 32'h02, "status_after_midframe_reset");
    wb_read(2'd1, 32'h1047, "div_after_midframe_reset");

    repeat (5) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("rd_q_drained", rd_exp.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
